pixel_dither_pack: RTL and testbench

// - Stage directly downstream of the colour blend unit: takes 8-bit/channel blended RGB plus screen x/y.
// - Applies the PSX 4x4 ordered dither when enabled, clamps and reduces each channel to 5 bits, and inserts the mask bit.
// - Merges horizontally adjacent pixels of the same 32-bit VRAM word into one write.
// - Issues 32-bit word writes with per-halfword selects to the VRAM write arbiter.

---
 rtl/pixel_dither_pack_pkg.sv | 29 ++
 rtl/pixel_dither_pack_clamp.sv | 18 +
 rtl/pixel_dither_pack.sv | 187 ++++++++++++++++++
 tb/tb_pixel_dither_pack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_dither_pack_pkg.sv
// Shared pixel-output types and constants: PSX ordered-dither matrix, 16-bit VRAM pixel
// layout and default address widths used by the dither/pack stage.
package pixel_dither_pack_pkg;

    localparam int XW_DEF  = 10;
    localparam int YW_DEF  = 9;
    localparam int WADDR_W = XW_DEF - 1 + YW_DEF;

    // Indexed [y[1:0]][x[1:0]]
    localparam logic signed [3:0] DITHER [4][4] = '{
        '{-4'sd4,  4'sd0, -4'sd3,  4'sd1},
        '{ 4'sd2, -4'sd2,  4'sd3, -4'sd1},
        '{-4'sd3,  4'sd1, -4'sd4,  4'sd0},
        '{ 4'sd3, -4'sd1,  4'sd2, -4'sd2}
    };

    typedef struct packed {
        logic       mask;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } pix16_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/pixel_dither_pack_clamp.sv
// One colour channel: optional signed dither offset, clamp to 0..255, reduce to 5 bits.
// Purely combinational.
module dither_clamp5 (
    input  logic [7:0]        i_c,
    input  logic signed [3:0] i_d,
    input  logic              i_en,
    output logic [4:0]        o_c5
);

    logic [9:0] sum;
    logic       unused_lo;

    // Range is -4..258, so bit 9 flags underflow and bit 8 flags overflow
    assign sum       = {2'b00, i_c} + (i_en ? {{6{i_d[3]}}, i_d} : 10'd0);
    assign o_c5      = sum[9] ? 5'd0 : (sum[8] ? 5'd31 : sum[7:3]);
    assign unused_lo = ^sum[2:0];

endmodule

// File: rtl/pixel_dither_pack.sv
// Dither/clamp to 15-bit colour plus mask, pair horizontally adjacent pixels of one
// VRAM word into a single halfword-selected 32-bit write towards the VRAM arbiter.
module pixel_dither_pack
    import pixel_dither_pack_pkg::*;
#(
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF,
    parameter int MERGE_EN = 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:0]        i_r,
    input  logic [7:0]        i_g,
    input  logic [7:0]        i_b,
    input  logic              i_stp,
    input  logic [XW-1:0]     i_x,
    input  logic [YW-1:0]     i_y,
    input  logic              i_dither,
    input  logic              i_forceMask,
    input  logic              i_flush,
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [XW-2+YW:0]  o_waddr,
    output logic [31:0]       o_wdata,
    output logic [1:0]        o_wsel,
    output logic              o_idle
);

    localparam int AW = XW - 1 + YW;

    logic signed [3:0] dith;
    logic [4:0]        r5, g5, b5;
    pix16_t            pix_in;
    logic              in_fire;

    logic st1_vld_q, st1_vld_d, st1_half_q, st1_half_d;
    pix16_t st1_pix_q, st1_pix_d;
    logic [AW-1:0] st1_addr_q, st1_addr_d;
    logic [31:0] st1_wdata;
    logic [1:0]  st1_wsel;

    hold_state_e state_q, state_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [31:0]   hold_wdata_q, hold_wdata_d;
    logic [1:0]    hold_wsel_q, hold_wsel_d;

    logic          wvalid_q, wvalid_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    wsel_q, wsel_d;

    logic          out_free, pair_hit, st1_adv, hold_load, out_load;
    logic [AW-1:0] out_addr_n;
    logic [31:0]   out_wdata_n;
    logic [1:0]    out_wsel_n;

    assign dith = DITHER[i_y[1:0]][i_x[1:0]];

    dither_clamp5 u_r (.i_c(i_r), .i_d(dith), .i_en(i_dither), .o_c5(r5));
    dither_clamp5 u_g (.i_c(i_g), .i_d(dith), .i_en(i_dither), .o_c5(g5));
    dither_clamp5 u_b (.i_c(i_b), .i_d(dith), .i_en(i_dither), .o_c5(b5));

    assign pix_in    = '{mask: i_forceMask | i_stp, b: b5, g: g5, r: r5};
    assign o_ready   = !st1_vld_q | st1_adv;
    assign in_fire   = i_valid & o_ready;
    assign out_free  = !wvalid_q | i_wready;
    assign st1_wdata = st1_half_q ? {st1_pix_q, 16'h0000} : {16'h0000, st1_pix_q};
    assign st1_wsel  = st1_half_q ? 2'b10 : 2'b01;
    assign pair_hit  = st1_vld_q && (hold_addr_q == st1_addr_q) && (hold_wsel_q[1] != st1_half_q);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= ST_EMPTY;
            st1_vld_q    <= 1'b0;
            st1_half_q   <= 1'b0;
            st1_pix_q    <= '0;
            st1_addr_q   <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_wsel_q  <= '0;
            wvalid_q     <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wsel_q       <= '0;
        end else begin
            state_q      <= state_d;
            st1_vld_q    <= st1_vld_d;
            st1_half_q   <= st1_half_d;
            st1_pix_q    <= st1_pix_d;
            st1_addr_q   <= st1_addr_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_wsel_q  <= hold_wsel_d;
            wvalid_q     <= wvalid_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wsel_q       <= wsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (MERGE_EN != 0) begin
            case (state_q)
                ST_EMPTY: if (st1_vld_q) state_d = ST_HOLD;
                ST_HOLD: begin
                    if (out_free && pair_hit)                 state_d = ST_EMPTY;
                    else if (out_free && !st1_vld_q && i_flush) state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Holder is only ever emitted when the output register can take it, which is what
    // keeps write order intact under back-pressure.
    always_comb begin
        st1_adv     = 1'b0;
        hold_load   = 1'b0;
        out_load    = 1'b0;
        out_addr_n  = st1_addr_q;
        out_wdata_n = st1_wdata;
        out_wsel_n  = st1_wsel;
        if (MERGE_EN == 0) begin
            if (st1_vld_q && out_free) begin
                st1_adv  = 1'b1;
                out_load = 1'b1;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (st1_vld_q) begin
                        st1_adv   = 1'b1;
                        hold_load = 1'b1;
                    end
                end
                ST_HOLD: begin
                    out_addr_n  = hold_addr_q;
                    out_wdata_n = hold_wdata_q;
                    out_wsel_n  = hold_wsel_q;
                    if (st1_vld_q && out_free) begin
                        st1_adv  = 1'b1;
                        out_load = 1'b1;
                        if (pair_hit) begin
                            out_wdata_n = hold_wdata_q | st1_wdata;
                            out_wsel_n  = 2'b11;
                        end else begin
                            hold_load = 1'b1;
                        end
                    end else if (!st1_vld_q && i_flush && out_free) begin
                        out_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        st1_vld_d    = st1_vld_q & !st1_adv;
        st1_half_d   = st1_half_q;
        st1_pix_d    = st1_pix_q;
        st1_addr_d   = st1_addr_q;
        if (in_fire) begin
            st1_vld_d  = 1'b1;
            st1_half_d = i_x[0];
            st1_pix_d  = pix_in;
            st1_addr_d = {i_y, i_x[XW-1:1]};
        end
        hold_addr_d  = hold_load ? st1_addr_q : hold_addr_q;
        hold_wdata_d = hold_load ? st1_wdata  : hold_wdata_q;
        hold_wsel_d  = hold_load ? st1_wsel   : hold_wsel_q;
        wvalid_d     = out_load | (wvalid_q & !i_wready);
        waddr_d      = out_load ? out_addr_n  : waddr_q;
        wdata_d      = out_load ? out_wdata_n : wdata_q;
        wsel_d       = out_load ? out_wsel_n  : wsel_q;
    end

    assign o_wvalid = wvalid_q;
    assign o_waddr  = waddr_q;
    assign o_wdata  = wdata_q;
    assign o_wsel   = wsel_q;
    assign o_idle   = !st1_vld_q && (state_q == ST_EMPTY) && !wvalid_q;

endmodule

// File: tb/tb_pixel_dither_pack.sv
// Directed bench for pixel_dither_pack: expected writes are queued by the stimulus
// thread and popped/compared by an independent write monitor.
module tb_pixel_dither_pack;
    import pixel_dither_pack_pkg::*;

    typedef struct packed {
        logic [WADDR_W-1:0] a;
        logic [31:0]        d;
        logic [1:0]         s;
    } wr_t;

    logic clk = 1'b0;
    logic i_rst, i_valid, o_ready, i_stp, i_dither, i_forceMask, i_flush;
    logic o_wvalid, i_wready, o_idle;
    logic [7:0] i_r, i_g, i_b;
    logic [9:0] i_x;
    logic [8:0] i_y;
    logic [WADDR_W-1:0] o_waddr;
    logic [31:0] o_wdata;
    logic [1:0]  o_wsel;

    int  tests = 0;
    int  fails = 0;
    bit  saw_low = 1'b0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    pixel_dither_pack #(.XW(10), .YW(9), .MERGE_EN(1)) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_stp(i_stp), .i_x(i_x), .i_y(i_y),
        .i_dither(i_dither), .i_forceMask(i_forceMask), .i_flush(i_flush),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_wsel(o_wsel), .o_idle(o_idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input int a, input logic [31:0] d, input logic [1:0] s);
        wr_t w;
        w.a = a[WADDR_W-1:0];
        w.d = d;
        w.s = s;
        return w;
    endfunction

    task automatic send(input int x, input int y, input int r, input int g, input int b,
                        input bit stp, input bit fm, input bit dth);
        bit rdy;
        bit ok;
        i_x = x[9:0]; i_y = y[8:0];
        i_r = r[7:0]; i_g = g[7:0]; i_b = b[7:0];
        i_stp = stp; i_forceMask = fm; i_dither = dth;
        i_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            rdy = o_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        i_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic flush();
        bit ok;
        i_flush = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (o_idle) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("flush_idle", {63'd0, ok}, 64'd1);
    endtask

    // Write monitor: pops one expectation per accepted write and checks stall stability
    initial begin : monitor
        wr_t got;
        wr_t want;
        wr_t prev;
        bit  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = '{a: o_waddr, d: o_wdata, s: o_wsel};
            if (!i_rst && prev_stall) begin
                check("stall_valid", {63'd0, o_wvalid}, 64'd1);
                check("stall_stable", 64'(got), 64'(prev));
            end
            if (!i_rst && o_wvalid && i_wready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(got), 64'd0);
                end else begin
                    want = exp_q.pop_front();
                    check("write_addr", 64'(got.a), 64'(want.a));
                    check("write_data", 64'(got.d), 64'(want.d));
                    check("write_sel",  64'(got.s), 64'(want.s));
                end
            end
            prev_stall = !i_rst && o_wvalid && !i_wready;
            prev = got;
        end
    end

    initial begin : stim
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_wready = 1'b1;
        i_r = 8'd0; i_g = 8'd0; i_b = 8'd0; i_x = '0; i_y = '0;
        i_stp = 1'b0; i_forceMask = 1'b0; i_dither = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("rst_wvalid", {63'd0, o_wvalid}, 64'd0);
        check("rst_waddr",  64'(o_waddr), 64'd0);
        check("rst_wdata",  64'(o_wdata), 64'd0);
        check("rst_wsel",   64'(o_wsel), 64'd0);
        check("rst_ready",  {63'd0, o_ready}, 64'd1);
        check("rst_idle",   {63'd0, o_idle}, 64'd1);
        @(posedge clk); #1;

        // Dither and clamp, one lone pixel per flush
        exp_q.push_back(mk(513, 32'h0000_001F, 2'b01));
        send(2, 1, 254, 0, 0, 0, 0, 1); flush();
        exp_q.push_back(mk(0, 32'h0000_7D80, 2'b01));
        send(0, 0, 2, 100, 255, 0, 0, 1); flush();
        exp_q.push_back(mk(0, 32'h0000_800C, 2'b01));
        send(0, 0, 100, 0, 0, 1, 0, 1); flush();
        exp_q.push_back(mk(0, 32'h801F_0000, 2'b10));
        send(1, 0, 255, 0, 0, 0, 1, 0); flush();
        exp_q.push_back(mk(1025, 32'h0421_0000, 2'b10));
        send(3, 2, 8, 8, 8, 0, 0, 0); flush();

        // Even/odd pair merges into one write
        exp_q.push_back(mk(5122, 32'h83E0_0002, 2'b11));
        send(4, 10, 16, 0, 0, 0, 0, 0);
        send(5, 10, 0, 255, 0, 1, 0, 0);
        flush();

        // Odd then even across a word boundary stays two writes
        exp_q.push_back(mk(3586, 32'h0421_0000, 2'b10));
        exp_q.push_back(mk(3587, 32'h0000_7FFF, 2'b01));
        send(5, 7, 8, 8, 8, 0, 0, 0);
        send(6, 7, 255, 255, 255, 0, 0, 0);
        flush();
        check("split_idle", {63'd0, o_idle}, 64'd1);

        // Same half twice keeps order, no merge
        exp_q.push_back(mk(2, 32'h0000_0001, 2'b01));
        exp_q.push_back(mk(2, 32'h0000_0002, 2'b01));
        send(4, 0, 8, 0, 0, 0, 0, 0);
        send(4, 0, 16, 0, 0, 0, 0, 0);
        flush();

        // Streamed pairs with a 5-cycle write stall
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(10240 + k, {16'(2 * k + 1), 16'(2 * k)}, 2'b11));
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, 20, 8 * i, 0, 0, 0, 0, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 i_wready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!o_ready) saw_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                i_wready = 1'b1;
            end
        join
        flush();
        check("bp_ready_dropped", {63'd0, saw_low}, 64'd1);

        // Reset while holding with a stalled write: nothing must come out
        i_wready = 1'b0;
        send(8, 1, 8, 0, 0, 0, 0, 0);
        send(10, 1, 16, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_wvalid", {63'd0, o_wvalid}, 64'd1);
        @(posedge clk); #1 i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_wvalid", {63'd0, o_wvalid}, 64'd0);
        check("mid_rst_idle",   {63'd0, o_idle}, 64'd1);
        check("mid_rst_ready",  {63'd0, o_ready}, 64'd1);
        @(posedge clk); #1 i_wready = 1'b1;

        exp_q.push_back(mk(516, 32'h0002_0001, 2'b11));
        send(8, 1, 8, 0, 0, 0, 0, 0);
        send(9, 1, 16, 0, 0, 0, 0, 0);
        flush();

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
